// File: rtl/regport_arbiter_pkg.sv
// Shared definitions for the register-port arbiter: state encoding and
// requester indices.
package regport_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic REQ0_IDX = 1'b0;
   localparam logic REQ1_IDX = 1'b1;

endpackage

// File: rtl/regport_arbiter_mux.sv
// 4-bit 2:1 address mux feeding the shared register-address port.
module Mux_8_4 (
   input  logic       sel,
   input  logic [3:0] D_in0,
   input  logic [3:0] D_in1,
   output logic [3:0] D_out
);

   assign D_out = sel ? D_in1 : D_in0;

endmodule

// File: rtl/regport_arbiter.sv
// Round-robin arbiter for the shared 4-bit register-address port, with a
// bounded hold so a continuously requesting owner yields to a waiting peer.
module regport_arbiter
   import regport_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int HOLD_W   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] addr0,
   input  logic [3:0] addr1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       sel,
   output logic [3:0] addr_out,
   output logic       bus_valid
);

   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

   state_t            state, state_nxt, other_own;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              last_owner, last_nxt;
   logic              sel_q, sel_nxt;
   logic              holder_req, other_req;

   always_comb begin
      state_nxt  = state;
      hold_nxt   = hold_cnt;
      last_nxt   = last_owner;
      sel_nxt    = sel_q;
      holder_req = (state == OWN1) ? req1 : req0;
      other_req  = (state == OWN1) ? req0 : req1;
      other_own  = (state == OWN1) ? OWN0 : OWN1;

      case (state)
         IDLE: begin
            if (req0 && req1)
               state_nxt = (last_owner == REQ1_IDX) ? OWN0 : OWN1;
            else if (req0)
               state_nxt = OWN0;
            else if (req1)
               state_nxt = OWN1;
         end
         OWN0, OWN1: begin
            if (!holder_req)
               state_nxt = other_req ? other_own : IDLE;
            else if (other_req && hold_cnt == HOLD_LIM)
               state_nxt = other_own;
            else if (hold_cnt != HOLD_LIM)
               hold_nxt = hold_cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      // Any change of owner (or going idle) restarts the tenure count.
      if (state_nxt != state || state_nxt == IDLE)
         hold_nxt = '0;

      if (state_nxt == OWN0) begin
         last_nxt = REQ0_IDX;
         sel_nxt  = REQ0_IDX;
      end else if (state_nxt == OWN1) begin
         last_nxt = REQ1_IDX;
         sel_nxt  = REQ1_IDX;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         last_owner <= REQ1_IDX;
         sel_q      <= REQ0_IDX;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         last_owner <= last_nxt;
         sel_q      <= sel_nxt;
      end
   end

   assign gnt0      = (state == OWN0);
   assign gnt1      = (state == OWN1);
   assign bus_valid = (state != IDLE);
   assign sel       = sel_q;

   Mux_8_4 u_addr_mux (
      .sel   (sel_q),
      .D_in0 (addr0),
      .D_in1 (addr1),
      .D_out (addr_out)
   );

endmodule
